// File: rtl/mem8x8_ctrl.sv
// Access controller for an 8x8 bitcell array: sequences per-row we/re/ren strobes and
// complementary column data, and captures the shared outp bus into rdata.
module mem8x8_ctrl #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 8,
    parameter int ADDR_W        = 3,
    parameter int STROBE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic              ready,
    output logic              rvalid,
    output logic [WIDTH-1:0]  rdata,
    output logic [DEPTH-1:0]  we,
    output logic [DEPTH-1:0]  re,
    output logic [DEPTH-1:0]  ren,
    output logic [WIDTH-1:0]  inp,
    output logic [WIDTH-1:0]  inpn,
    input  logic [WIDTH-1:0]  outp
);

    typedef enum logic [2:0] {
        IDLE, W_SETUP, W_STROBE, W_HOLD, R_STROBE, R_DONE
    } state_e;

    localparam logic [3:0] LAST = 4'(STROBE_CYCLES - 1);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DEPTH-1:0]   we_q, we_d;
    logic [DEPTH-1:0]   re_q, re_d;
    logic [DEPTH-1:0]   ren_q;
    logic [WIDTH-1:0]   inp_q, inp_d;
    logic [WIDTH-1:0]   inpn_q;
    logic [WIDTH-1:0]   rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;
    logic [DEPTH-1:0]   req_row;
    logic [DEPTH-1:0]   cur_row;

    // One-hot row decodes for the incoming and the latched address.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dec
        assign req_row[gi] = (addr   == ADDR_W'(gi));
        assign cur_row[gi] = (addr_q == ADDR_W'(gi));
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        we_d     = we_q;
        re_d     = re_q;
        inp_d    = inp_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d = addr;
                    cnt_d  = '0;
                    if (wr) begin
                        state_d = W_SETUP;
                        inp_d   = wdata;
                    end else begin
                        state_d = R_STROBE;
                        re_d    = req_row;
                    end
                end
            end
            W_SETUP: begin
                state_d = W_STROBE;
                we_d    = cur_row;
                cnt_d   = '0;
            end
            W_STROBE: begin
                if (cnt_q == LAST) begin
                    state_d = W_HOLD;
                    we_d    = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            W_HOLD: begin
                state_d = IDLE;
            end
            R_STROBE: begin
                // outp is only trusted on the last strobe edge, while re is still high.
                if (cnt_q == LAST) begin
                    state_d  = R_DONE;
                    rdata_d  = outp;
                    re_d     = '0;
                    rvalid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            R_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                we_d    = '0;
                re_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            we_q     <= '0;
            re_q     <= '0;
            ren_q    <= '1;
            inp_q    <= '0;
            inpn_q   <= '1;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            re_q     <= re_d;
            ren_q    <= ~re_d;
            inp_q    <= inp_d;
            inpn_q   <= ~inp_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign ready  = (state_q == IDLE);
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign we     = we_q;
    assign re     = re_q;
    assign ren    = ren_q;
    assign inp    = inp_q;
    assign inpn   = inpn_q;

endmodule
